// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants and types for the instruction-fetch stage.
//   PC_WIDTH : datapath / program-counter width in bits
//   PC_INCR  : sequential PC increment in bytes
//   RESET_PC : PC value loaded by reset
//   addr_t   : PC_WIDTH-bit address type
package fetch_pkg;

   localparam int          PC_WIDTH = 64;
   localparam int unsigned PC_INCR  = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   typedef logic [PC_WIDTH-1:0] addr_t;

endpackage : fetch_pkg

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg -- W-bit rising-edge register with synchronous active-high
// reset to RST_VAL. Holds the program counter of the fetch stage.
// Ports:
//   clk   : clock, all updates on the rising edge
//   reset : synchronous active-high reset, loads RST_VAL
//   d     : next value
//   q     : registered value
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int             W       = fetch_pkg::PC_WIDTH,
   parameter logic [W-1:0]   RST_VAL = W'(fetch_pkg::RESET_PC)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) q <= RST_VAL;
      else       q <= d;
   end

endmodule : fetch_pc_reg

// File: rtl/fetch.sv
// fetch -- instruction-fetch stage. Holds the PC and drives it directly as
// the instruction-memory address. Each edge the PC advances by PC_INCR, or
// loads PCBranch_F when PCSrc_F is high; reset has priority over both.
// Arithmetic is unsigned modulo 2^N (the top address wraps to 0).
// Ports:
//   PCSrc_F     : 1 = load PCBranch_F, 0 = PC + PC_INCR
//   clk         : clock, rising-edge
//   reset       : synchronous active-high reset, PC <= RESET_PC
//   PCBranch_F  : branch/jump target address (N bits)
//   imem_addr_F : current PC, registered (N bits)
// Build option:
//   FETCH_BRANCH_ALIGN_EN : when defined, branch targets are forced to a
//                           word boundary (low two bits cleared) before load.
module fetch
#(
   parameter int           N        = fetch_pkg::PC_WIDTH,
   parameter int unsigned  PC_INCR  = fetch_pkg::PC_INCR,
   parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC)
) (
   input  logic         PCSrc_F,
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] PCBranch_F,
   output logic [N-1:0] imem_addr_F
);

   import fetch_pkg::*;

   logic [N-1:0] pc;
   logic [N-1:0] pc_plus;
   logic [N-1:0] branch_tgt;
   logic [N-1:0] pc_next;

   // Wraps naturally: the sum is truncated to N bits.
   assign pc_plus = pc + N'(PC_INCR);

`ifdef FETCH_BRANCH_ALIGN_EN
   // Clear the byte offset within the 4-byte word.
   assign branch_tgt = PCBranch_F & ~N'(3);
`else
   assign branch_tgt = PCBranch_F;
`endif

   assign pc_next = PCSrc_F ? branch_tgt : pc_plus;

   fetch_pc_reg #(
      .W       (N),
      .RST_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .d     (pc_next),
      .q     (pc)
   );

   // Straight from the register: no combinational path from the inputs.
   assign imem_addr_F = pc;

endmodule : fetch

// File: tb/tb_fetch.sv
// tb_fetch -- self-checking bench for fetch. Directed steps from the test
// plan followed by randomized cycles, all compared against a reference
// model of the PC kept as a plain 64-bit variable.
module tb_fetch;

   localparam int N = 64;

`ifdef FETCH_BRANCH_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         PCSrc_F;
   logic [N-1:0] PCBranch_F;
   logic [N-1:0] imem_addr_F;

   int errors = 0;
   int checks = 0;

   logic [N-1:0] model_pc;

   always #10 clk = ~clk;

   fetch dut (
      .PCSrc_F     (PCSrc_F),
      .clk         (clk),
      .reset       (reset),
      .PCBranch_F  (PCBranch_F),
      .imem_addr_F (imem_addr_F)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: what the PC must hold after one edge with these inputs.
   function automatic logic [N-1:0] next_pc(input logic [N-1:0] cur, input logic r,
                                            input logic s, input logic [N-1:0] t);
      if (r)      return '0;
      else if (s) return ALIGN ? (t - (t % 4)) : t;
      else        return cur + 64'd4;
   endfunction

   // Drive inputs, take one rising edge, then compare 1 ns after it.
   task automatic step(input logic r, input logic s, input logic [N-1:0] t, input string tag);
      reset      = r;
      PCSrc_F    = s;
      PCBranch_F = t;
      @(posedge clk);
      model_pc = next_pc(model_pc, r, s, t);
      #1;
      check(tag, imem_addr_F, model_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] t;
      logic         r, s;
      model_pc = 'x;

      // 1. Reset held for 50 ns (three edges) with a branch target present.
      step(1'b1, 1'b0, 64'd5, "reset_e1");
      step(1'b1, 1'b0, 64'd5, "reset_e2");
      step(1'b1, 1'b0, 64'd5, "reset_e3");
      check("reset_const", imem_addr_F, 64'd0);

      // 2. Sequential increment.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'd5, "seq");
      check("seq_const", imem_addr_F, 64'd16);

      // 3. Branch to 5, held.
      step(1'b0, 1'b1, 64'd5, "branch5");
      check("branch5_const", imem_addr_F, ALIGN ? 64'd4 : 64'd5);
      step(1'b0, 1'b1, 64'd5, "branch5_hold");

      // 4. Target changed mid-cycle: no effect until the next edge.
      #9;
      PCBranch_F = 64'd15;
      #1;
      check("midcycle_no_effect", imem_addr_F, model_pc);
      @(posedge clk);
      model_pc = next_pc(model_pc, 1'b0, 1'b1, 64'd15);
      #1;
      check("branch15", imem_addr_F, model_pc);
      check("branch15_const", imem_addr_F, ALIGN ? 64'd12 : 64'd15);

      // 5. Wrap at the top of the address space.
      step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "wrap_load");
      step(1'b0, 1'b0, 64'd0, "wrap");
      check("wrap_const", imem_addr_F, 64'd0);

      // 6. Reset priority over a branch, then release.
      step(1'b0, 1'b0, 64'd0, "pre_rst");
      step(1'b1, 1'b1, 64'h100, "rst_priority");
      check("rst_priority_const", imem_addr_F, 64'd0);
      step(1'b0, 1'b0, 64'h100, "rst_release");
      check("rst_release_const", imem_addr_F, 64'd4);

      // Randomized traffic: occasional resets, branches to random and
      // near-wrap targets, sequential runs in between.
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 15) == 0);
         s = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         else                           t = {$urandom(), $urandom()};
         step(r, s, t, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch
